ahb_bram_ctrl: RTL

AHB-Lite slave that fronts the dual-port block RAM as zero-wait-state memory for the Cortex-M0 bus. It translates AHB address/data phases into the RAM's byte-enabled write port (A) and registered read port (B). It forwards write data to the read port on a same-word read-after-write, and returns a two-cycle ERROR response for illegal transfers. It sits directly upstream of the block RAM, between the bus matrix and the memory array.

---
 rtl/ahb_bram_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ahb_bram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_bram_ctrl
//  Description : AHB-Lite zero-wait slave in front of a dual-port block RAM.
//                Port A takes byte-enabled writes in the AHB data phase.
//                Port B is read with a registered one-cycle latency.
//                A same-word write is forwarded into a read that overlaps it.
//                Illegal transfers get a two-cycle ERROR response.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [3:0]            bram_wea,
  output logic [31:0]           bram_dina,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [31:0]           bram_doutb
);

  // Error-response state machine encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  // Transfer size codes
  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  logic [1:0]            r_state;

  // Address-phase decode
  logic                  w_accept;
  logic                  w_legal;
  logic [3:0]            w_mask;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_wr_go;
  logic                  w_rd_go;
  logic                  w_err_go;
  logic                  w_hit;

  // Data-phase bookkeeping
  logic                  r_wr_pend;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [3:0]            r_wr_mask;
  logic                  r_rd_pend;
  logic                  r_fwd;
  logic [31:0]           r_fwd_data;
  logic [3:0]            r_fwd_mask;

  // Upper address bits alias the memory and HTRANS[0] only separates
  // SEQ from NONSEQ, which this slave treats identically.
  logic                  w_unused;
  assign w_unused = &{1'b0, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  // ERR1 holds HREADY low on the bus, so nothing new can start there;
  // the extra term keeps the slave safe against a misbehaving master.
  assign w_accept = HSEL & HTRANS[1] & HREADY & (r_state != ST_ERR1);
  assign w_word   = HADDR[ADDR_WIDTH+1:2];

  // Size/alignment legality and byte-lane mask for the current address phase
  always_comb begin
    w_legal = 1'b0;
    w_mask  = 4'b0000;
    case (HSIZE)
      SZ_BYTE: begin
        w_legal = 1'b1;
        w_mask  = 4'b0001 << HADDR[1:0];
      end
      SZ_HALF: begin
        w_legal = ~HADDR[0];
        w_mask  = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        w_legal = (HADDR[1:0] == 2'b00);
        w_mask  = 4'b1111;
      end
      default: begin
        w_legal = 1'b0;
        w_mask  = 4'b0000;
      end
    endcase
  end

  assign w_wr_go  = w_accept &  w_legal &  HWRITE;
  assign w_rd_go  = w_accept &  w_legal & ~HWRITE;
  assign w_err_go = w_accept & ~w_legal;

  // A read whose address phase overlaps a write data phase to the same word
  // would see the old RAM contents, so the write is captured for overlay.
  assign w_hit = w_rd_go & r_wr_pend & (w_word == r_wr_addr);

  // Error-response sequencing: IDLE -> ERR1 -> ERR2 -> IDLE/ERR1
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= w_err_go ? ST_ERR1 : ST_IDLE;
        ST_ERR1: r_state <= ST_ERR2;
        ST_ERR2: r_state <= w_err_go ? ST_ERR1 : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write address phase capture; the write itself happens one cycle later
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_pend <= 1'b0;
      r_wr_addr <= '0;
      r_wr_mask <= 4'b0000;
    end else begin
      r_wr_pend <= w_wr_go;
      if (w_wr_go) begin
        r_wr_addr <= w_word;
        r_wr_mask <= w_mask;
      end
    end
  end

  // Read data-phase flag and same-word write forwarding capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rd_pend  <= 1'b0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
      r_fwd_mask <= 4'b0000;
    end else begin
      r_rd_pend <= w_rd_go;
      r_fwd     <= w_hit;
      if (w_hit) begin
        r_fwd_data <= HWDATA;
        r_fwd_mask <= r_wr_mask;
      end
    end
  end

  // RAM port A is driven only while a legal write owns the data phase
  assign bram_wea   = r_wr_pend ? r_wr_mask : 4'b0000;
  assign bram_addra = r_wr_addr;
  assign bram_dina  = HWDATA;

  // RAM port B follows the bus address so the accept edge samples it
  assign bram_addrb = w_word;

  // Per-lane read data: forwarded byte where the overlapping write hit it
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign HRDATA[8*g +: 8] = !r_rd_pend                   ? 8'h00 :
                              (r_fwd && r_fwd_mask[g])     ? r_fwd_data[8*g +: 8] :
                                                             bram_doutb[8*g +: 8];
  end

  assign HREADYOUT = (r_state != ST_ERR1);
  assign HRESP     = (r_state != ST_IDLE);

endmodule
`default_nettype wire
